// File: rtl/netlist_bist_harness_if.sv
// netlist_bist_harness_if: pad-ring side signals of the netlist BIST harness
interface netlist_bist_harness_if #(
  parameter int N_IN  = 11,
  parameter int N_OUT = 17
);
  logic             start;
  logic             abort;
  logic [N_OUT-1:0] golden;
  logic [N_OUT-1:0] resp;
  logic [N_IN-1:0]  stim;
  logic             dut_reset_n;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_OUT-1:0] signature;
  modport master (
    output start, abort, golden, resp,
    input  stim, dut_reset_n, busy, done, pass, signature
  );
  modport slave (
    input  start, abort, golden, resp,
    output stim, dut_reset_n, busy, done, pass, signature
  );
endinterface

// File: rtl/netlist_bist_harness.sv
// netlist_bist_harness: LFSR stimulus and MISR compaction self-test wrapped around a gate netlist
module netlist_bist_harness #(
  parameter int                N_IN      = 11,
  parameter int                N_OUT     = 17,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'h0001,
  parameter logic [N_OUT-1:0]  MISR_POLY = 17'h10009,
  parameter int                NUM_PAT   = 256,
  parameter int                LAT       = 0,
  parameter int                RST_CYC   = 4
) (
  input logic                   bertaClock,
  input logic                   global_reset,
  netlist_bist_harness_if.slave bus
);
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;
  if (N_IN > LFSR_W) begin : g_bad_width
    $error("N_IN must not exceed LFSR_W");
  end
  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_nx;
  logic [N_OUT-1:0]  misr_q, misr_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [3:0]        lat_q, lat_d;
  logic              dut_rst_n_q, dut_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              run, flush, smp;
  assign run     = state_q == RUN;
  assign flush   = bus.abort || (state_q == IDLE);
  assign lfsr_nx = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  // Valid bits track which edges carry a response that belongs to a RUN pattern
  if (LAT == 0) begin : g_nolat
    assign smp = run;
  end else begin : g_lat
    logic [LAT-1:0] vld_q, vld_d;
    always_comb vld_d = flush ? '0 : LAT'({vld_q, run});
    always_ff @(posedge bertaClock or negedge global_reset)
      if (!global_reset) vld_q <= '0;
      else vld_q <= vld_d;
    assign smp = vld_q[LAT-1];
  end
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = (smp && !bus.abort)
            ? (({misr_q[N_OUT-2:0], 1'b0} ^ (misr_q[N_OUT-1] ? MISR_POLY : '0)) ^ bus.resp)
            : misr_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q + 16'd1;
    lat_d   = lat_q + 4'd1;
    pass_d  = pass_q;
    if (bus.abort) begin
      state_d = IDLE;
      stim_d  = '0;
      cnt_d   = '0;
      lat_d   = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          stim_d = '0;
          cnt_d  = '0;
          if (bus.start) begin
            state_d = INIT;
            lfsr_d  = SEED_EFF;
            misr_d  = '0;
            pass_d  = 1'b0;
          end
        end
        INIT: if (cnt_q == 16'(RST_CYC - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
          stim_d  = lfsr_q[N_IN-1:0];
          lfsr_d  = lfsr_nx;
        end
        RUN: begin
          lfsr_d = lfsr_nx;
          stim_d = lfsr_q[N_IN-1:0];
          if (cnt_q == 16'(NUM_PAT - 1)) begin
            state_d = (LAT == 0) ? DONE : DRAIN;
            stim_d  = stim_q;
            lat_d   = '0;
          end
        end
        DRAIN: state_d = (lat_q == 4'(LAT - 1)) ? DONE : DRAIN;
        DONE: begin
          state_d = IDLE;
          stim_d  = '0;
          pass_d  = misr_q == bus.golden;
        end
        default: state_d = IDLE;
      endcase
    end
    dut_rst_n_d = state_d != INIT;
    busy_d      = state_d != IDLE;
    done_d      = state_d == DONE;
  end
  always_ff @(posedge bertaClock or negedge global_reset) begin
    if (!global_reset) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_EFF;
      misr_q      <= '0;
      stim_q      <= '0;
      cnt_q       <= '0;
      lat_q       <= '0;
      dut_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      stim_q      <= stim_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      dut_rst_n_q <= dut_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end
  assign bus.stim        = stim_q;
  assign bus.dut_reset_n = dut_rst_n_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.signature   = misr_q;
endmodule

// File: tb/tb_netlist_bist_harness.sv
// tb_netlist_bist_harness: directed vectors for the BIST harness at LAT=0 and LAT=2
module tb_netlist_bist_harness;
  logic clk = 1'b0;
  logic rst_n;
  logic lp;
  logic [10:0] d1 = '0, d2 = '0;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  netlist_bist_harness_if #(.N_IN(11), .N_OUT(17)) bus0 ();
  netlist_bist_harness_if #(.N_IN(11), .N_OUT(17)) bus2 ();
  netlist_bist_harness #(.NUM_PAT(4), .LAT(0)) u_dut0 (.bertaClock(clk), .global_reset(rst_n), .bus(bus0));
  netlist_bist_harness #(.NUM_PAT(4), .LAT(2)) u_dut2 (.bertaClock(clk), .global_reset(rst_n), .bus(bus2));
  // dut2 sees a netlist with two cycles of latency
  always @(posedge clk) begin
    d1 <= bus2.stim;
    d2 <= d1;
  end
  assign bus0.resp = lp ? {6'b0, bus0.stim} : '0;
  assign bus2.resp = {6'b0, d2};
  typedef struct {
    logic [10:0] stim;
    logic [16:0] sig;
    logic        done, busy, drn, pass;
  } obs_t;
  typedef struct {
    int          dut;
    int          c;
    logic [10:0] stim;
    logic [16:0] sig;
    logic        done, busy, drn, pass;
  } row_t;
  obs_t tr0 [1:12];
  obs_t tr2 [1:12];
  row_t tbl [16];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask
  task automatic run(input int restart_at, input int abort_at);
    bus0.start = 1'b1;
    bus2.start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      tr0[c] = '{bus0.stim, bus0.signature, bus0.done, bus0.busy, bus0.dut_reset_n, bus0.pass};
      tr2[c] = '{bus2.stim, bus2.signature, bus2.done, bus2.busy, bus2.dut_reset_n, bus2.pass};
      bus0.start = (c == restart_at);
      bus2.start = bus0.start;
      bus0.abort = (c == abort_at);
    end
  endtask
  task automatic chk_t2(input string tg);
    int nd = 0;
    logic [16:0] acc = '0;
    for (int k = 0; k < 4; k++) chk($sformatf("%s stim%0d", tg, k), 32'(tr0[5+k].stim), 32'(1 << k));
    for (int c = 1; c <= 12; c++) begin
      nd += int'(tr0[c].done);
      acc |= tr0[c].sig;
    end
    chk({tg, " done count"}, 32'(nd), 1);
    chk({tg, " done c9"}, 32'(tr0[9].done), 1);
    chk({tg, " sig zero"}, 32'(acc), 0);
    chk({tg, " pass"}, 32'(tr0[10].pass), 1);
  endtask
  initial begin
    rst_n = 1'b1;
    lp = 1'b0;
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.golden = '0;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.golden = '0;
    // LAT=0 loopback rows, then LAT=2 delayed-loopback rows
    tbl[0]  = '{0, 1,  11'h000, 17'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{0, 4,  11'h000, 17'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{0, 5,  11'h001, 17'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{0, 6,  11'h002, 17'h1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{0, 7,  11'h004, 17'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{0, 8,  11'h008, 17'h4, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{0, 9,  11'h008, 17'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{0, 10, 11'h000, 17'h0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{2, 4,  11'h000, 17'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{2, 5,  11'h001, 17'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{2, 7,  11'h004, 17'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{2, 8,  11'h008, 17'h1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{2, 9,  11'h008, 17'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{2, 10, 11'h008, 17'h4, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{2, 11, 11'h008, 17'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{2, 12, 11'h000, 17'h0, 1'b0, 1'b0, 1'b1, 1'b1};
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1 stim", 32'(bus0.stim), 0);
    chk("t1 dut_reset_n", 32'(bus0.dut_reset_n), 0);
    chk("t1 busy", 32'(bus0.busy), 0);
    chk("t1 done", 32'(bus0.done), 0);
    chk("t1 pass", 32'(bus0.pass), 0);
    chk("t1 sig", 32'(bus0.signature), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1 release dut_reset_n", 32'(bus0.dut_reset_n), 1);
    chk("t1 release busy", 32'(bus0.busy), 0);
    run(0, 0);
    chk_t2("t2");
    lp = 1'b1;
    bus0.golden = 17'h1;
    run(0, 0);
    chk("t3 pass cleared on start", 32'(tr0[1].pass), 0);
    chk("t3 golden1 sig", 32'(tr0[10].sig), 0);
    chk("t3 golden1 pass", 32'(tr0[10].pass), 0);
    bus0.golden = '0;
    run(6, 0);
    for (int i = 0; i < 16; i++) begin
      obs_t o;
      o = (tbl[i].dut == 0) ? tr0[tbl[i].c] : tr2[tbl[i].c];
      chk($sformatf("row%0d d%0d c%0d stim", i, tbl[i].dut, tbl[i].c), 32'(o.stim), 32'(tbl[i].stim));
      chk($sformatf("row%0d d%0d c%0d sig", i, tbl[i].dut, tbl[i].c), 32'(o.sig), 32'(tbl[i].sig));
      chk($sformatf("row%0d d%0d c%0d done", i, tbl[i].dut, tbl[i].c), 32'(o.done), 32'(tbl[i].done));
      chk($sformatf("row%0d d%0d c%0d busy", i, tbl[i].dut, tbl[i].c), 32'(o.busy), 32'(tbl[i].busy));
      chk($sformatf("row%0d d%0d c%0d drn", i, tbl[i].dut, tbl[i].c), 32'(o.drn), 32'(tbl[i].drn));
      chk($sformatf("row%0d d%0d c%0d pass", i, tbl[i].dut, tbl[i].c), 32'(o.pass), 32'(tbl[i].pass));
    end
    begin
      int fd = 0;
      for (int c = 1; c <= 12; c++) if (tr2[c].done && fd == 0) fd = c;
      chk("t4 first done cycle", 32'(fd), 11);
    end
    run(0, 7);
    chk("t5 abort stim", 32'(tr0[8].stim), 0);
    chk("t5 abort busy", 32'(tr0[8].busy), 0);
    chk("t5 abort dut_reset_n", 32'(tr0[8].drn), 1);
    chk("t5 abort pass", 32'(tr0[8].pass), 0);
    chk("t5 abort sig frozen", 32'(tr0[8].sig), 0);
    begin
      int nd = 0;
      for (int c = 1; c <= 12; c++) nd += int'(tr0[c].done);
      chk("t5 no done", 32'(nd), 0);
    end
    run(0, 0);
    chk("t5 rerun stim0", 32'(tr0[5].stim), 1);
    chk("t5 rerun sig c6", 32'(tr0[6].sig), 1);
    chk("t5 rerun pass", 32'(tr0[10].pass), 1);
    bus0.start = 1'b1;
    bus0.abort = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    chk("t6 start+abort busy", 32'(bus0.busy), 0);
    chk("t6 abort idle pass", 32'(bus0.pass), 0);
    @(negedge clk);
    chk("t6 start+abort stays idle", 32'(bus0.busy), 0);
    bus0.start = 1'b1;
    bus2.start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus0.start = 1'b0;
      bus2.start = 1'b0;
    end
    chk("t6 pre-reset sig", 32'(bus0.signature), 1);
    rst_n = 1'b0;
    #1;
    chk("t6 reset stim", 32'(bus0.stim), 0);
    chk("t6 reset dut_reset_n", 32'(bus0.dut_reset_n), 0);
    chk("t6 reset busy", 32'(bus0.busy), 0);
    chk("t6 reset sig", 32'(bus0.signature), 0);
    chk("t6 reset busy dut2", 32'(bus2.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6 release dut_reset_n", 32'(bus0.dut_reset_n), 1);
    lp = 1'b0;
    run(0, 0);
    chk_t2("t6 recovery");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
